// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request; the slave returns status and result.
interface serial_adder_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first.
// Produces sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   serial_adder_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sr_q;
   logic             c_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             s_d;
   logic             c_d;
   logic [WIDTH-1:0] sr_d;
   logic             last_d;

   always_comb begin
      s_d    = a_q[0] ^ b_q[0] ^ c_q;
      c_d    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
      sr_d   = {s_d, sr_q[WIDTH-1:1]};
      last_d = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sr_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  c_q     <= bus.cin;
                  sr_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= c_d;
               sr_q  <= sr_d;
               cnt_q <= cnt_q + CW'(1);
               // c_q here is the carry into the MSB, so c_q ^ c_d is signed overflow
               if (last_d) begin
                  sum_q   <= sr_d;
                  cout_q  <= c_d;
                  ovf_q   <= c_q ^ c_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule
